// File: rtl/bk_pkg.sv
// Shared bkController definitions: command width and opcode encodings.
package bk_pkg;
  localparam int CMD_W = 7;

  localparam logic [2:0] OPC_LOAD  = 3'b101;
  localparam logic [2:0] OPC_STORE = 3'b110;
  localparam logic [2:0] OPC_NOP   = 3'b111;
endpackage

// File: rtl/bk_cmd_fifo.sv
// Command storage ring: unreset array, wrapping pointers and an independent level counter.
module bk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/bk_cmd_queue.sv
// Host-to-bkController command queue with optional parity check / NOP rewrite.
// Optional feature macro: BK_CMDQ_PARITY_EN.
module bk_cmd_queue
  import bk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  input  logic [7:0]             host_data,
  output logic                   host_ready,
  input  logic                   cmd_take,
  output logic [CMD_W-1:0]       cmd_out,
  output logic                   cmd_valid,
  output logic                   p_error,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic [7:0]             err_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef BK_CMDQ_PARITY_EN
  localparam int EW = CMD_W + 1;
`else
  localparam int EW = CMD_W;
`endif

  // Handshake: a word transfers on a rising edge where host_valid & host_ready;
  // the host holds host_data until then. cmd_take is a single-cycle strobe and
  // pops only when cmd_valid; ready/valid depend on registered state alone.
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  assign host_ready = (level != LW'(DEPTH));
  assign cmd_valid  = (level != '0);
  assign push       = host_valid & host_ready;
  assign pop        = cmd_take & cmd_valid;

  bk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .level (level)
  );

`ifdef BK_CMDQ_PARITY_EN
  logic par_err;
  assign par_err  = ^host_data;
  // A bad word keeps its selects but becomes NOP so the controller flags it.
  assign wr_entry = par_err ? {1'b1, host_data[6:3], OPC_NOP}
                            : {1'b0, host_data[6:0]};
  assign cmd_out  = cmd_valid ? head_entry[CMD_W-1:0] : {4'b0000, OPC_NOP};
  assign p_error  = cmd_valid & head_entry[CMD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_cnt <= '0;
    else if (push && par_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_parity;
  assign unused_parity = host_data[7];
  assign wr_entry = host_data[6:0];
  assign cmd_out  = cmd_valid ? head_entry : {4'b0000, OPC_NOP};
  assign p_error  = 1'b0;
  assign err_cnt  = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     underrun <= 1'b0;
    else if (cmd_take && !cmd_valid) underrun <= 1'b1;
  end
endmodule

// File: tb/tb_bk_cmd_queue.sv
// Directed self-checking bench for bk_cmd_queue (DEPTH = 4), either parity build.
module tb_bk_cmd_queue;
  import bk_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       cmd_take;
  logic [6:0] cmd_out;
  logic       cmd_valid;
  logic       p_error;
  logic [2:0] level;
  logic       underrun;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  bk_cmd_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .cmd_take   (cmd_take),
    .cmd_out    (cmd_out),
    .cmd_valid  (cmd_valid),
    .p_error    (p_error),
    .level      (level),
    .underrun   (underrun),
    .err_cnt    (err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1ns after a rising edge, outputs read there too
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    host_valid = 1'b1;
    host_data  = d;
    cycle();
    host_valid = 1'b0;
  endtask

  task automatic take();
    cmd_take = 1'b1;
    cycle();
    cmd_take = 1'b0;
  endtask

  function automatic logic [7:0] even_word(input logic [6:0] c);
    return {^c, c};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; host_valid = 1'b0; host_data = 8'h00; cmd_take = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_host_ready got=%b exp=1", host_ready); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    total++; if (cmd_out !== 7'h07) begin bad++; $display("FAIL reset_cmd_out got=%h exp=07", cmd_out); end
    total++; if (p_error !== 1'b0) begin bad++; $display("FAIL reset_p_error got=%b exp=0", p_error); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_push_basic();
    push_word(8'h05);
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", cmd_valid); end
    total++; if (cmd_out !== 7'h05) begin bad++; $display("FAIL basic_cmd got=%h exp=05", cmd_out); end
    total++; if (p_error !== 1'b0) begin bad++; $display("FAIL basic_p_error got=%b exp=0", p_error); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL basic_level got=%0d exp=1", level); end
    take();
    total++; if (cmd_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL basic_pop valid=%b level=%0d exp 0/0", cmd_valid, level); end
    total++; if (cmd_out !== 7'h07) begin bad++; $display("FAIL basic_empty_cmd got=%h exp=07", cmd_out); end
  endtask

  task automatic test_parity();
    logic [6:0] e1, e2;
    logic       pe;
    logic [7:0] ec1, ec2;
`ifdef BK_CMDQ_PARITY_EN
    e1 = 7'h07; e2 = 7'h5F; pe = 1'b1; ec1 = 8'd1; ec2 = 8'd2;
`else
    e1 = 7'h05; e2 = 7'h5D; pe = 1'b0; ec1 = 8'd0; ec2 = 8'd0;
`endif
    push_word(8'h85);
    total++; if (cmd_out !== e1) begin bad++; $display("FAIL parity1_cmd got=%h exp=%h", cmd_out, e1); end
    total++; if (p_error !== pe) begin bad++; $display("FAIL parity1_p_error got=%b exp=%b", p_error, pe); end
    total++; if (err_cnt !== ec1) begin bad++; $display("FAIL parity1_err_cnt got=%0d exp=%0d", err_cnt, ec1); end
    take();
    total++; if (p_error !== 1'b0) begin bad++; $display("FAIL parity_empty_p_error got=%b exp=0", p_error); end
    push_word(8'h5D);
    total++; if (cmd_out !== e2) begin bad++; $display("FAIL parity2_cmd got=%h exp=%h", cmd_out, e2); end
    total++; if (err_cnt !== ec2) begin bad++; $display("FAIL parity2_err_cnt got=%0d exp=%0d", err_cnt, ec2); end
    take();
    push_word(8'hDD);
    total++; if (cmd_out !== 7'h5D || p_error !== 1'b0) begin bad++; $display("FAIL parity_good_cmd got=%h/%b exp=5d/0", cmd_out, p_error); end
    total++; if (err_cnt !== ec2) begin bad++; $display("FAIL parity_good_err_cnt got=%0d exp=%0d", err_cnt, ec2); end
    take();
  endtask

  task automatic test_full();
    logic [6:0] words [4];
    logic [6:0] exp;
    words[0] = 7'h05; words[1] = 7'h06; words[2] = 7'h03; words[3] = 7'h7E;
    for (int i = 0; i < 4; i++) begin
      push_word(even_word(words[i]));
      exp_q.push_back(words[i]);
    end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", level); end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", host_ready); end
    push_word(8'h0F);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_no_push level=%0d exp=4", level); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL full_underrun got=%b exp=0", underrun); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      total++; if (cmd_out !== exp) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, cmd_out, exp); end
      take();
      if (i == 0) begin
        total++; if (host_ready !== 1'b1 || level !== 3'd3) begin bad++; $display("FAIL full_ready_rise ready=%b level=%0d exp 1/3", host_ready, level); end
      end
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL full_drain level=%0d exp=0", level); end
  endtask

  task automatic test_underrun();
    take();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL underrun_level got=%0d exp=0", level); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    host_valid = 1'b1; host_data = 8'h05; cmd_take = 1'b1;
    cycle();
    host_valid = 1'b0; cmd_take = 1'b0;
    total++; if (level !== 3'd1 || cmd_out !== 7'h05) begin bad++; $display("FAIL underrun_push level=%0d cmd=%h exp 1/05", level, cmd_out); end
    push_word(8'h06);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    take(); take();
  endtask

  task automatic test_back_to_back();
    logic [6:0] c;
    logic [6:0] exp;
    push_word(8'h11); exp_q.push_back(7'h11);
    push_word(8'h22); exp_q.push_back(7'h22);
    total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_start level=%0d exp=2", level); end
    for (int i = 0; i < 10; i++) begin
      c = 7'(i * 13 + 3);
      exp = exp_q.pop_front();
      exp_q.push_back(c);
      total++; if (cmd_out !== exp) begin bad++; $display("FAIL b2b_head[%0d] got=%h exp=%h", i, cmd_out, exp); end
      host_valid = 1'b1; host_data = even_word(c); cmd_take = 1'b1;
      cycle();
      host_valid = 1'b0; cmd_take = 1'b0;
      total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level); end
    end
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      total++; if (cmd_out !== exp) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, cmd_out, exp); end
      take();
    end
  endtask

  task automatic test_async_reset();
    push_word(8'h05); push_word(8'h06); push_word(8'h03);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL areset_pre level=%0d exp=3", level); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", cmd_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL areset_level got=%0d exp=0", level); end
    total++; if (cmd_out !== 7'h07) begin bad++; $display("FAIL areset_cmd got=%h exp=07", cmd_out); end
    total++; if (underrun !== 1'b0 || err_cnt !== 8'd0 || host_ready !== 1'b1) begin bad++; $display("FAIL areset_misc underrun=%b err_cnt=%0d ready=%b exp 0/0/1", underrun, err_cnt, host_ready); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_parity();
    test_full();
    test_underrun();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bk_cmd_queue.md
# bk_cmd_queue

Command queue directly upstream of `bkController`. It accepts 8-bit parity-protected command words from the host and buffers them in a small FIFO. It presents the head command on the 7-bit `cmd_in` bus the controller latches in its PAUSE state, and advances on a one-cycle take strobe. Parity failures are flagged on `p_error` and rewritten to NOP, so the controller routes them through NOP and raises `nvalid_data`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CMD_W`, 7: command width, {sel_a[6:5], sel_b[4:3], opcode[2:0]}.
- One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `host_valid` in 1: host word valid.
- `host_data` in 8: [7] even-parity bit, [6:0] command.
- `host_ready` out 1: queue can accept (= not full).
- `cmd_take` in 1: one-cycle pulse; controller consumed head.
- `cmd_out` out CMD_W: head command, feeds controller `cmd_in`.
- `cmd_valid` out 1: head entry present.
- `p_error` out 1: head entry failed parity.
- `level` out $clog2(DEPTH)+1: entries stored.
- `underrun` out 1: sticky; take seen while empty.
- `err_cnt` out 8: saturating count of parity-failed pushes.

## Operation
- Push when `host_valid & host_ready`. Pop when `cmd_take & cmd_valid`.
- `host_ready = (level != DEPTH)`. There is no push at full; the host holds `host_data` until ready.
- Parity check on push: error = XOR of `host_data[7:0]` is 1. Store the per-entry error flag alongside the command.
- Error entry: stored command = {host_data[6:3], OPC_NOP}. `p_error` is high while that entry is head.
- Empty head: `cmd_out` = {4'b0000, OPC_NOP}, `cmd_valid` = 0, `p_error` = 0.
- `cmd_take` while empty: no pointer change; `underrun` set to 1 and held until reset.
- Simultaneous push and pop with 0 < level < DEPTH: `level` unchanged, both pointers advance.
- Simultaneous push and pop at empty: the pop is ignored (`underrun` set) and the push is stored.
- At full, pop only; `host_ready` rises the next cycle.
- Pointers wrap modulo DEPTH. `level` is an independent counter, 0..DEPTH.
- `err_cnt` increments on each error push and saturates at 255.

## Timing
- Reset values: `host_ready` = 1, `cmd_valid` = 0, `cmd_out` = 7'b0000111, `p_error` = 0, `level` = 0, `underrun` = 0, `err_cnt` = 0. Storage array is not reset.
- Push to visible at head: 1 cycle. There is no fall-through from `host_data` to `cmd_out`.
- Pop: the next head appears the cycle after the `cmd_take` edge.
- `cmd_out` and `p_error` are driven from registered storage only, so they are stable for the controller's PAUSE latch.
- `host_ready`, `cmd_valid` and `level` are derived from registered state only. There is no combinational path from `host_valid` or `cmd_take`.
- Reset mid-operation: all entries are discarded immediately; outputs go to their reset values asynchronously.

## Configuration
- `BK_CMDQ_PARITY_EN` defined:
  - parity checked;
  - NOP substitution applied;
  - `p_error` and `err_cnt` live.
- Not defined:
  - `host_data[7]` is ignored;
  - commands are stored unmodified;
  - `p_error` is tied 0 and `err_cnt` is tied 0;
  - no per-entry flag storage.

## Structure
- Shared package `bk_pkg`:
  - `CMD_W`;
  - opcode constants `OPC_LOAD` = 3'b101, `OPC_STORE` = 3'b110, `OPC_NOP` = 3'b111.
  - These constants are shared with `bkController`.
- Sub-module `bk_cmd_fifo`: storage array, pointers and level counter, parameterised on DEPTH and entry width (CMD_W, or CMD_W+1 with parity enabled).
- The top level holds the parity check, NOP rewrite, `underrun` and `err_cnt`.

## Test plan
- Reset release, then push 0x05 (cmd 7'h05, parity 0) → next cycle: `cmd_valid` = 1, `cmd_out` = 7'h05, `p_error` = 0, `level` = 1.
- Push 0x85 (bad parity; macro on) → head `cmd_out` = 7'h07, `p_error` = 1, `err_cnt` = 1. With the macro off: `cmd_out` = 7'h05, `p_error` = 0.
- Push 4 words with DEPTH = 4 → `host_ready` = 0 and `level` = 4. Pulse `cmd_take` → `host_ready` = 1 the next cycle; commands pop in push order.
- `cmd_take` at empty → `level` stays 0, `underrun` = 1 and stays set after later pushes.
- Push and take in the same cycle at `level` = 2 → `level` stays 2. Wrap the pointers over 10 push/pop pairs with no reordering.
- Assert `rst_n` low with `level` = 3 → `cmd_valid` = 0, `level` = 0, `cmd_out` = 7'h07 without waiting for a clock edge.
